// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined add/subtract unit: op encoding, segment sizing
// and the elaboration-time legality check on WIDTH/STAGES.
`ifndef ADDER_PKG_SV
`define ADDER_PKG_SV

`define ADDER_CHECK_PARAMS(W, S) \
    if (((S) < 1) || ((S) > (W)) || (((W) % (S)) != 0)) begin : g_bad_params \
        $error("adder_pipe: WIDTH must be a positive multiple of STAGES"); \
    end

package adder_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    function automatic int seg_width(input int width, input int stages);
        return width / stages;
    endfunction

endpackage

`endif

// File: rtl/adder_1b.sv
// Single-bit full adder cell, the building block of every ripple segment.
module adder_1b (
    input  logic a,
    input  logic b,
    input  logic carry_in,
    output logic sum,
    output logic carry_out
);

    assign sum       = a ^ b ^ carry_in;
    assign carry_out = (a & b) | (carry_in & (a ^ b));

endmodule

// File: rtl/adder_seg.sv
// Combinational SEG_W-bit ripple segment built from adder_1b cells; also exposes the
// carry entering its top bit so the last segment can produce signed overflow.
module adder_seg #(
    parameter int SEG_W = 8
) (
    input  logic [SEG_W-1:0] a,
    input  logic [SEG_W-1:0] b,
    input  logic             carry_in,
    output logic [SEG_W-1:0] sum,
    output logic             carry_out,
    output logic             msb_carry_in
);

    // Each bit keeps its own carry nets so the chain is not one self-referencing vector.
    for (genvar i = 0; i < SEG_W; i++) begin : g_bit
        logic cin_s;
        logic cout_s;

        if (i == 0) begin : g_lsb
            assign cin_s = carry_in;
        end else begin : g_chain
            assign cin_s = g_bit[i-1].cout_s;
        end

        adder_1b u_cell (
            .a         (a[i]),
            .b         (b[i]),
            .carry_in  (cin_s),
            .sum       (sum[i]),
            .carry_out (cout_s)
        );
    end

    assign carry_out    = g_bit[SEG_W-1].cout_s;
    assign msb_carry_in = g_bit[SEG_W-1].cin_s;

endmodule

// File: rtl/adder_pipe.sv
// Pipelined add/subtract unit: the carry chain is cut into STAGES registered segments,
// with a valid/ready handshake whose ready chain lets bubbles collapse.
module adder_pipe
    import adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic             busy
);

    localparam int SEG_W = seg_width(WIDTH, STAGES);

    `ADDER_CHECK_PARAMS(WIDTH, STAGES)

    logic [STAGES-1:0] valid_s;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO_W   = k * SEG_W;
        localparam int DONE_W = LO_W + SEG_W;
        localparam int SRC_W  = WIDTH - LO_W;
        localparam int REM_W  = WIDTH - DONE_W;

        logic              src_valid_s;
        logic [SRC_W-1:0]  src_a_s;
        logic [SRC_W-1:0]  src_b_s;
        logic              src_carry_s;
        logic [SEG_W-1:0]  seg_sum_s;
        logic              seg_carry_s;
        logic              seg_msbc_s;
        logic [DONE_W-1:0] sum_in_s;
        logic              down_ready_s;
        logic              load_s;
        logic              data_ld_s;

        logic              valid_q, valid_d;
        logic [DONE_W-1:0] sum_q, sum_d;
        logic              carry_q, carry_d;
        logic              msbc_q, msbc_d;

        // B is inverted once at issue; later stages forward it already conditioned.
        if (k == 0) begin : g_first
            assign src_valid_s = in_valid;
            assign src_a_s     = a;
            assign src_b_s     = b ^ {WIDTH{op_e'(op_sub) == OP_SUB}};
            assign src_carry_s = carry_in;
            assign sum_in_s    = seg_sum_s;
        end else begin : g_next
            assign src_valid_s = g_stage[k-1].valid_q;
            assign src_a_s     = g_stage[k-1].g_fwd.a_q;
            assign src_b_s     = g_stage[k-1].g_fwd.b_q;
            assign src_carry_s = g_stage[k-1].carry_q;
            assign sum_in_s    = {seg_sum_s, g_stage[k-1].sum_q};
        end

        if (k == STAGES - 1) begin : g_tail
            assign down_ready_s = out_ready;
        end else begin : g_mid
            assign down_ready_s = g_stage[k+1].load_s;
        end

        assign load_s     = !valid_q || down_ready_s;
        assign data_ld_s  = load_s && src_valid_s;
        assign valid_s[k] = valid_q;

        adder_seg #(
            .SEG_W (SEG_W)
        ) u_seg (
            .a            (src_a_s[SEG_W-1:0]),
            .b            (src_b_s[SEG_W-1:0]),
            .carry_in     (src_carry_s),
            .sum          (seg_sum_s),
            .carry_out    (seg_carry_s),
            .msb_carry_in (seg_msbc_s)
        );

        // Next state: data only moves with a real beat, so a stalled stage holds its result.
        always_comb begin
            valid_d = load_s    ? src_valid_s : valid_q;
            sum_d   = data_ld_s ? sum_in_s    : sum_q;
            carry_d = data_ld_s ? seg_carry_s : carry_q;
            msbc_d  = data_ld_s ? seg_msbc_s  : msbc_q;
        end

        // Stage register with asynchronous clear.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                valid_q <= 1'b0;
                sum_q   <= '0;
                carry_q <= 1'b0;
                msbc_q  <= 1'b0;
            end else begin
                valid_q <= valid_d;
                sum_q   <= sum_d;
                carry_q <= carry_d;
                msbc_q  <= msbc_d;
            end
        end

        if (REM_W > 0) begin : g_fwd
            logic [REM_W-1:0] a_q, a_d;
            logic [REM_W-1:0] b_q, b_d;

            // Forward only the operand bits later segments still need.
            always_comb begin
                a_d = data_ld_s ? src_a_s[SRC_W-1:SEG_W] : a_q;
                b_d = data_ld_s ? src_b_s[SRC_W-1:SEG_W] : b_q;
            end

            // Forwarded operand register.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else begin
                    a_q <= a_d;
                    b_q <= b_d;
                end
            end
        end
    end

    assign in_ready  = g_stage[0].load_s;
    assign out_valid = valid_s[STAGES-1];
    assign busy      = |valid_s;
    assign sum       = g_stage[STAGES-1].sum_q;
    assign carry_out = g_stage[STAGES-1].carry_q;
    assign overflow  = g_stage[STAGES-1].carry_q ^ g_stage[STAGES-1].msbc_q;

endmodule
